// File: rtl/lcd_write_engine.sv
// HD44780-class LCD write engine: timed RS/RW/E/DB sequencing, 8/4-bit bus, cursor tracking with auto line wrap.
// Define LCD_BUSY_POLL_EN to replace the fixed execution wait with busy-flag polling.
module lcd_write_engine #(
    parameter int BUS_4BIT    = 0,
    parameter int T_SETUP_CYC = 8,
    parameter int T_EN_CYC    = 50,
    parameter int T_HOLD_CYC  = 4,
    parameter int T_EXEC_CYC  = 4000,
    parameter int T_LONG_CYC  = 164000,
    parameter int COLS        = 16,
    parameter int LINES       = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       InValid,
    output logic       InReady,
    input  logic       InRS,
    input  logic [7:0] InData,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] DB,
    output logic       DBOe,
    input  logic [7:0] DBIn,
    output logic       Done,
    output logic [1:0] Line,
    output logic [5:0] Col
);
    localparam int NSET  = (T_SETUP_CYC < 1) ? 1 : T_SETUP_CYC;
    localparam int NEN   = (T_EN_CYC    < 1) ? 1 : T_EN_CYC;
    localparam int NHOLD = (T_HOLD_CYC  < 1) ? 1 : T_HOLD_CYC;
    localparam int NEXEC = (T_EXEC_CYC  < 1) ? 1 : T_EXEC_CYC;
    localparam int NLONG = (T_LONG_CYC  < 1) ? 1 : T_LONG_CYC;
    localparam int M0    = (NSET > NEN) ? NSET : NEN;
    localparam int M1    = (M0 > NHOLD) ? M0 : NHOLD;
    localparam int M2    = (M1 > NEXEC) ? M1 : NEXEC;
    localparam int NMAX  = (M2 > NLONG) ? M2 : NLONG;
    localparam int CW    = $clog2(NMAX + 1);

    localparam logic [CW-1:0] LD_SET  = CW'(NSET - 1);
    localparam logic [CW-1:0] LD_EN   = CW'(NEN - 1);
    localparam logic [CW-1:0] LD_HOLD = CW'(NHOLD - 1);
    localparam logic [CW-1:0] LD_LONG = CW'(NLONG - 1);
    localparam logic          FOUR    = (BUS_4BIT != 0);

`ifdef LCD_BUSY_POLL_EN
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, PSETUP, PPULSE, PHOLD} state_t;
`else
    localparam logic [CW-1:0] LD_EXEC = CW'(NEXEC - 1);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;
`endif

    typedef struct packed {
        logic       hit;
        logic [1:0] line;
        logic [5:0] col;
    } map_t;

    function automatic logic [6:0] line_base(input logic [1:0] l);
        case (l)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    // Walk lines from the top down so the lowest matching line wins on overlap.
    function automatic map_t addr_map(input logic [6:0] a);
        map_t m;
        int   b;
        m = '0;
        for (int l = LINES - 1; l >= 0; l--) begin
            b = int'(line_base(2'(l)));
            if (int'(a) >= b && int'(a) < b + COLS) begin
                m.hit  = 1'b1;
                m.line = 2'(l);
                m.col  = 6'(int'(a) - b);
            end
        end
        return m;
    endfunction

    function automatic logic [7:0] bus_word(input logic [7:0] b, input logic lo);
        if (!FOUR) return b;
        return lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
    endfunction

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      byte_q;
    logic            nib;
    logic            long_q;
    logic            wrap_pend;
    logic            xfer_end;
    logic            is_home;
    logic            col_last;
    logic [1:0]      line_next;
    map_t            amap;
    logic [7:0]      wrap_cmd;

    assign is_home   = (InData == 8'h01) || (InData == 8'h02) || (InData == 8'h03);
    assign col_last  = (({1'b0, Col} + 7'd1) == 7'(COLS));
    assign line_next = (Line == 2'(LINES - 1)) ? 2'd0 : Line + 2'd1;
    assign amap      = addr_map(InData[6:0]);
    assign wrap_cmd  = {1'b1, line_base(Line)};

`ifdef LCD_BUSY_POLL_EN
    logic [CW-1:0] tmo;
    logic          pnib;
    logic          busy_q;
    logic          unused_dbin;
    assign unused_dbin = ^DBIn[6:0];

    always_comb begin
        xfer_end = 1'b0;
        if (state == PSETUP || state == PPULSE || state == PHOLD) begin
            if (tmo == '0)
                xfer_end = 1'b1;
            else if (state == PHOLD && cnt == '0 && !(FOUR && !pnib) && !busy_q)
                xfer_end = 1'b1;
        end
    end
`else
    logic unused_dbin;
    assign unused_dbin = ^DBIn;
    assign RW = 1'b0;

    always_comb begin
        xfer_end = (state == EXEC) && (cnt == '0);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_q    <= '0;
            nib       <= 1'b0;
            long_q    <= 1'b0;
            wrap_pend <= 1'b0;
            InReady   <= 1'b0;
            RS        <= 1'b0;
            E         <= 1'b0;
            DB        <= '0;
            DBOe      <= 1'b0;
            Done      <= 1'b0;
            Line      <= '0;
            Col       <= '0;
`ifdef LCD_BUSY_POLL_EN
            RW        <= 1'b0;
            tmo       <= '0;
            pnib      <= 1'b0;
            busy_q    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (InValid && InReady) begin
                        InReady <= 1'b0;
                        byte_q  <= InData;
                        nib     <= 1'b0;
                        long_q  <= !InRS && is_home;
                        RS      <= InRS;
                        DB      <= bus_word(InData, 1'b0);
                        DBOe    <= 1'b1;
                        cnt     <= LD_SET;
                        state   <= SETUP;
                        // Tracking moves at accept so a wrap can address the new line.
                        if (InRS) begin
                            if (col_last) begin
                                Col       <= '0;
                                Line      <= line_next;
                                wrap_pend <= 1'b1;
                            end else begin
                                Col <= Col + 6'd1;
                            end
                        end else if (is_home) begin
                            Line <= '0;
                            Col  <= '0;
                        end else if (InData[7] && amap.hit) begin
                            Line <= amap.line;
                            Col  <= amap.col;
                        end
                    end else begin
                        InReady <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        E     <= 1'b1;
                        cnt   <= LD_EN;
                        state <= PULSE;
                    end else cnt <= cnt - CW'(1);
                end
                PULSE: begin
                    if (cnt == '0) begin
                        E     <= 1'b0;
                        cnt   <= LD_HOLD;
                        state <= HOLD;
                    end else cnt <= cnt - CW'(1);
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if (FOUR && !nib) begin
                            nib   <= 1'b1;
                            DB    <= bus_word(byte_q, 1'b1);
                            cnt   <= LD_SET;
                            state <= SETUP;
                        end else begin
                            DB   <= '0;
                            DBOe <= 1'b0;
                            RS   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
                            RW    <= 1'b1;
                            pnib  <= 1'b0;
                            tmo   <= LD_LONG;
                            cnt   <= LD_SET;
                            state <= PSETUP;
`else
                            cnt   <= long_q ? LD_LONG : LD_EXEC;
                            state <= EXEC;
`endif
                        end
                    end else cnt <= cnt - CW'(1);
                end
`ifdef LCD_BUSY_POLL_EN
                PSETUP: begin
                    if (cnt == '0) begin
                        E     <= 1'b1;
                        cnt   <= LD_EN;
                        state <= PPULSE;
                    end else cnt <= cnt - CW'(1);
                end
                PPULSE: begin
                    if (cnt == '0) begin
                        E <= 1'b0;
                        // Only the first read of a 4-bit pair carries the busy flag.
                        if (!pnib) busy_q <= DBIn[7];
                        cnt   <= LD_HOLD;
                        state <= PHOLD;
                    end else cnt <= cnt - CW'(1);
                end
                PHOLD: begin
                    if (cnt == '0) begin
                        pnib  <= FOUR && !pnib;
                        cnt   <= LD_SET;
                        state <= PSETUP;
                    end else cnt <= cnt - CW'(1);
                end
`else
                EXEC: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
`endif
                default: state <= IDLE;
            endcase

`ifdef LCD_BUSY_POLL_EN
            if ((state == PSETUP || state == PPULSE || state == PHOLD) && tmo != '0)
                tmo <= tmo - CW'(1);
`endif

            if (xfer_end) begin
                E <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
                RW <= 1'b0;
`endif
                if (wrap_pend) begin
                    wrap_pend <= 1'b0;
                    byte_q    <= wrap_cmd;
                    long_q    <= 1'b0;
                    nib       <= 1'b0;
                    RS        <= 1'b0;
                    DB        <= bus_word(wrap_cmd, 1'b0);
                    DBOe      <= 1'b1;
                    cnt       <= LD_SET;
                    state     <= SETUP;
                end else begin
                    Done    <= 1'b1;
                    InReady <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine: an 8-bit and a 4-bit instance with shortened timing.
module tb_lcd_write_engine;
    localparam int S8 = 3, P8 = 4, H8 = 2, X8 = 6, L8 = 20;
    localparam int S4 = 2, P4 = 3, H4 = 0, X4 = 5, L4 = 12;
    localparam int BUDGET = 200;
    localparam int NV = 21;

    logic clk = 1'b0, rst = 1'b1;
    logic v8 = 1'b0, v4 = 1'b0, in_rs = 1'b0;
    logic [7:0] in_data = '0, dbin = '0;
    logic r8, rs8, rw8, e8, oe8, done8;
    logic r4, rs4, rw4, e4, oe4, done4;
    logic [7:0] db8, db4;
    logic [1:0] line8, line4;
    logic [5:0] col8, col4;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    lcd_write_engine #(.BUS_4BIT(0), .T_SETUP_CYC(S8), .T_EN_CYC(P8), .T_HOLD_CYC(H8),
        .T_EXEC_CYC(X8), .T_LONG_CYC(L8), .COLS(16), .LINES(2)) u8 (
        .Clk(clk), .Reset(rst), .InValid(v8), .InReady(r8), .InRS(in_rs), .InData(in_data),
        .RS(rs8), .RW(rw8), .E(e8), .DB(db8), .DBOe(oe8), .DBIn(dbin), .Done(done8),
        .Line(line8), .Col(col8));

    lcd_write_engine #(.BUS_4BIT(1), .T_SETUP_CYC(S4), .T_EN_CYC(P4), .T_HOLD_CYC(H4),
        .T_EXEC_CYC(X4), .T_LONG_CYC(L4), .COLS(4), .LINES(4)) u4 (
        .Clk(clk), .Reset(rst), .InValid(v4), .InReady(r4), .InRS(in_rs), .InData(in_data),
        .RS(rs4), .RW(rw4), .E(e4), .DB(db4), .DBOe(oe4), .DBIn(dbin), .Done(done4),
        .Line(line4), .Col(col4));

    typedef struct packed {
        logic       rdy, rs, rw, e;
        logic [7:0] db;
        logic       oe, done;
        logic [1:0] line;
        logic [5:0] col;
    } obs_t;

    typedef struct {
        int lat, np, ehi, first_e, rdyv, oev, rwv, line, col;
        logic [7:0] db0, dbl;
        logic rs0, rsl;
    } res_t;

    typedef struct {
        int sel;
        logic rs;
        logic [7:0] d;
        int lat, np;
        logic [7:0] db0, dbl;
        logic rsl;
        int line, col;
    } vec_t;

    function automatic obs_t get(input int sel);
        if (sel == 0) return {r8, rs8, rw8, e8, db8, oe8, done8, line8, col8};
        return {r4, rs4, rw4, e4, db4, oe4, done4, line4, col4};
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", n, act, act, exp, exp);
        end
    endtask

    task automatic set_valid(input int sel, input logic b);
        if (sel == 0) v8 = b; else v4 = b;
    endtask

    // Leaves valid asserted; watch() drops it on the first cycle after the accept edge.
    task automatic accept(input int sel, input logic rs, input logic [7:0] d, output bit ok);
        obs_t o;
        int w;
        w = 0;
        @(negedge clk);
        in_rs = rs; in_data = d; set_valid(sel, 1'b1);
        o = get(sel);
        while (!o.rdy && w < 400) begin
            @(negedge clk); o = get(sel); w++;
        end
        ok = o.rdy;
        if (ok) @(posedge clk); else set_valid(sel, 1'b0);
    endtask

    task automatic watch(input int sel, input bit drop, output res_t r);
        obs_t o;
        logic pe;
        r.lat = -1; r.np = 0; r.ehi = 0; r.first_e = -1; r.rdyv = 0; r.oev = 0; r.rwv = 0;
        r.line = -1; r.col = -1; r.db0 = '0; r.dbl = '0; r.rs0 = 1'b0; r.rsl = 1'b0;
        pe = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (k == 0 && drop) set_valid(sel, 1'b0);
            o = get(sel);
            if (o.e) begin
                r.ehi++;
                if (!o.oe) r.oev++;
                if (!pe) begin
                    if (r.np == 0) begin r.db0 = o.db; r.rs0 = o.rs; r.first_e = k; end
                    r.dbl = o.db; r.rsl = o.rs; r.np++;
                end
            end
            if (o.rw) r.rwv++;
            if (o.done) begin
                r.lat = k; r.line = int'(o.line); r.col = int'(o.col);
                break;
            end
            if (o.rdy) r.rdyv++;
            pe = o.e;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vec_t vecs[NV];
        res_t r;
        bit ok;
        int s, p, seen, dn;

        // sel rs  data   lat np db0    dbl   rsl  line col
        vecs[0]  = '{0, 1'b1, 8'h41, 15, 1, 8'h41, 8'h41, 1'b1, 0, 1};
        vecs[1]  = '{0, 1'b0, 8'h01, 29, 1, 8'h01, 8'h01, 1'b0, 0, 0};
        vecs[2]  = '{0, 1'b0, 8'hC5, 15, 1, 8'hC5, 8'hC5, 1'b0, 1, 5};
        vecs[3]  = '{0, 1'b0, 8'h38, 15, 1, 8'h38, 8'h38, 1'b0, 1, 5};
        vecs[4]  = '{0, 1'b0, 8'h90, 15, 1, 8'h90, 8'h90, 1'b0, 1, 5};
        vecs[5]  = '{0, 1'b0, 8'h8F, 15, 1, 8'h8F, 8'h8F, 1'b0, 0, 15};
        vecs[6]  = '{0, 1'b1, 8'h5A, 30, 2, 8'h5A, 8'hC0, 1'b0, 1, 0};
        vecs[7]  = '{0, 1'b0, 8'h02, 29, 1, 8'h02, 8'h02, 1'b0, 0, 0};
        vecs[8]  = '{0, 1'b0, 8'hCF, 15, 1, 8'hCF, 8'hCF, 1'b0, 1, 15};
        vecs[9]  = '{0, 1'b1, 8'h21, 30, 2, 8'h21, 8'h80, 1'b0, 0, 0};
        vecs[10] = '{1, 1'b0, 8'h28, 17, 2, 8'h20, 8'h80, 1'b0, 0, 0};
        vecs[11] = '{1, 1'b0, 8'hD6, 17, 2, 8'hD0, 8'h60, 1'b0, 3, 2};
        vecs[12] = '{1, 1'b0, 8'h95, 17, 2, 8'h90, 8'h50, 1'b0, 2, 1};
        vecs[13] = '{1, 1'b1, 8'h33, 17, 2, 8'h30, 8'h30, 1'b1, 2, 2};
        vecs[14] = '{1, 1'b1, 8'h34, 17, 2, 8'h30, 8'h40, 1'b1, 2, 3};
        vecs[15] = '{1, 1'b1, 8'h35, 34, 4, 8'h30, 8'h40, 1'b0, 3, 0};
        vecs[16] = '{1, 1'b1, 8'h36, 17, 2, 8'h30, 8'h60, 1'b1, 3, 1};
        vecs[17] = '{1, 1'b0, 8'h84, 17, 2, 8'h80, 8'h40, 1'b0, 3, 1};
        vecs[18] = '{1, 1'b0, 8'h03, 24, 2, 8'h00, 8'h30, 1'b0, 0, 0};
        vecs[19] = '{1, 1'b0, 8'hD7, 17, 2, 8'hD0, 8'h70, 1'b0, 3, 3};
        vecs[20] = '{1, 1'b1, 8'h37, 34, 4, 8'h30, 8'h00, 1'b0, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset u8 outputs", int'({r8, rs8, rw8, e8, oe8, done8, line8, col8, db8}), 0);
        chk("reset u4 outputs", int'({r4, rs4, rw4, e4, oe4, done4, line4, col4, db4}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset u8", int'(r8), 1);
        chk("ready after reset u4", int'(r4), 1);

        for (int i = 0; i < NV; i++) begin
            s = (vecs[i].sel == 0) ? S8 : S4;
            p = (vecs[i].sel == 0) ? P8 : P4;
            accept(vecs[i].sel, vecs[i].rs, vecs[i].d, ok);
            chk($sformatf("v%0d accept", i), int'(ok), 1);
            watch(vecs[i].sel, 1'b1, r);
            chk($sformatf("v%0d done latency", i), r.lat, vecs[i].lat);
            chk($sformatf("v%0d pulse count", i), r.np, vecs[i].np);
            chk($sformatf("v%0d first E cycle", i), r.first_e, s);
            chk($sformatf("v%0d E high cycles", i), r.ehi, vecs[i].np * p);
            chk($sformatf("v%0d first DB", i), int'(r.db0), int'(vecs[i].db0));
            chk($sformatf("v%0d last DB", i), int'(r.dbl), int'(vecs[i].dbl));
            chk($sformatf("v%0d first RS", i), int'(r.rs0), int'(vecs[i].rs));
            chk($sformatf("v%0d last RS", i), int'(r.rsl), int'(vecs[i].rsl));
            chk($sformatf("v%0d ready while busy", i), r.rdyv, 0);
            chk($sformatf("v%0d DBOe low during E", i), r.oev, 0);
            chk($sformatf("v%0d RW high", i), r.rwv, 0);
            chk($sformatf("v%0d line", i), r.line, vecs[i].line);
            chk($sformatf("v%0d col", i), r.col, vecs[i].col);
        end

        // 32 data bytes from line 0 col 0: wrap to line 1 after 16, back to line 0 after 32
        for (int i = 0; i < 32; i++) begin
            accept(0, 1'b1, 8'(8'h41 + i), ok);
            watch(0, 1'b1, r);
            chk($sformatf("run%0d pulses", i), r.np, (i % 16 == 15) ? 2 : 1);
            chk($sformatf("run%0d line", i), r.line, ((i + 1) / 16) % 2);
            chk($sformatf("run%0d col", i), r.col, (i + 1) % 16);
            if (i == 15) chk("run15 wrap cmd", int'(r.dbl), 8'hC0);
            if (i == 31) chk("run31 wrap cmd", int'(r.dbl), 8'h80);
        end

        // Clear with InValid held: no accept until Done, then the held request goes in
        accept(0, 1'b0, 8'h01, ok);
        watch(0, 1'b0, r);
        chk("held clear latency", r.lat, S8 + P8 + H8 + L8);
        chk("held clear no early accept", r.rdyv, 0);
        chk("held clear single pulse", r.np, 1);
        watch(0, 1'b1, r);
        chk("held re-accept E cycle", r.first_e, S8);
        chk("held re-accept latency", r.lat, S8 + P8 + H8 + L8);

        // Reset during PULSE
        accept(0, 1'b0, 8'hC3, ok);
        watch(0, 1'b1, r);
        chk("pre-reset line", r.line, 1);
        chk("pre-reset col", r.col, 3);
        accept(0, 1'b1, 8'h77, ok);
        seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            @(negedge clk);
            v8 = 1'b0;
            if (e8) seen = 1;
        end
        chk("reached PULSE", seen, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-pulse reset E", int'(e8), 0);
        chk("mid-pulse reset outputs", int'({r8, rs8, rw8, oe8, done8, line8, col8, db8}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after mid-pulse reset", int'(r8), 1);
        dn = 0; seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done8) dn++;
            if (e8) seen++;
        end
        chk("no Done after reset", dn, 0);
        chk("no E after reset", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- Parametrised HD44780-class character LCD write engine, sitting between the text/init sequencers and the LCD pins.
- Accepts command or data bytes over a valid/ready handshake and generates RS/RW/E/DB with programmable setup, pulse, hold and execution timing.
- Supports 8-bit or 4-bit bus mode.
- Tracks the cursor and automatically inserts a set-DDRAM-address command at end of line, for 1 to 4 lines.

Parameters:
- BUS_4BIT, 0, 1 = 4-bit nibble mode on DB[7:4]; 0 = 8-bit mode
- T_SETUP_CYC, 8, Clk cycles RS/RW/DB stable before E rises
- T_EN_CYC, 50, Clk cycles E held high
- T_HOLD_CYC, 4, Clk cycles DB/RS held after E falls
- T_EXEC_CYC, 4000, Clk cycles of execution wait for a normal command or data byte
- T_LONG_CYC, 164000, Clk cycles of execution wait for clear (0x01) and home (0x02/0x03)
- COLS, 16, characters per line; legal range 1..40
- LINES, 2, display lines; legal range 1..4

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- InValid  in  1  request valid
- InReady  out  1  engine idle, can accept
- InRS  in  1  0 = command, 1 = character data
- InData  in  8  byte to write
- RS  out  1  LCD register select
- RW  out  1  LCD read/write (1 = read)
- E  out  1  LCD enable strobe
- DB  out  8  LCD data bus; in 4-bit mode DB[3:0] = 0
- DBOe  out  1  1 = engine drives DB
- DBIn  in  8  LCD bus readback (used only with optional feature)
- Done  out  1  one-cycle pulse when an accepted byte has fully completed
- Line  out  2  current cursor line
- Col  out  6  current cursor column

Behaviour:
- Reset: RS = RW = E = 0, DB = 0, DBOe = 0, Done = 0, Line = 0, Col = 0, InReady = 0 during the Reset cycle and 1 after it. Reset asserted mid-transfer forces E low on the next edge, discards the transfer and restarts in IDLE.
- Handshake: a transfer is accepted on a rising edge with InValid && InReady. InRS and InData are captured. InReady drops on the next cycle and returns only in IDLE. InValid with InReady = 0 is ignored; no queuing.
- States:
  - IDLE: waits for a transfer.
  - SETUP: T_SETUP_CYC cycles, RS/DB driven, DBOe = 1, E = 0.
  - PULSE: T_EN_CYC cycles, E = 1.
  - HOLD: T_HOLD_CYC cycles, E = 0, bus held.
  - NIB2: 4-bit mode only; repeats SETUP/PULSE/HOLD with the low nibble. The high nibble goes first.
  - EXEC: T_LONG_CYC cycles if the byte is a command 0x01, 0x02 or 0x03, else T_EXEC_CYC. Bus released to 0, DBOe = 0.
  - WRAP: issues an internal command through SETUP..EXEC.
- Latency: E rises T_SETUP_CYC + 1 cycles after the accept edge. In 8-bit mode Done pulses on the last EXEC cycle + 1.
- Counters: all counters load N-1 and terminate at 0. A parameter value of 0 is treated as 1.
- Cursor tracking:
  - Each data write increments Col.
  - When Col reaches COLS, Line advances modulo LINES, Col = 0, and WRAP issues 0x80 | base.
  - Line base addresses: 0x00, 0x40, 0x14, 0x54 for lines 0..3.
  - Done for the user byte pulses only after WRAP completes. InReady stays 0 throughout.
  - Commands 0x01, 0x02 and 0x03 set Line = 0, Col = 0.
  - A user command with bit7 = 1 sets tracking from its address: addresses 0x00/0x40/0x14/0x54 + n map to that line, column n. An unmapped address leaves tracking unchanged.
  - Other commands do not change tracking.
- RW = 0 always in the default build.

Optional Feature:
- Macro: LCD_BUSY_POLL_EN.
- Enabled: EXEC is replaced by POLL. DBOe = 0, RS = 0, RW = 1, then an E pulse with the same setup/pulse timing; DBIn[7] is sampled on the last PULSE cycle. In 4-bit mode a dummy second pulse is also issued. Polling repeats while busy = 1. If T_LONG_CYC elapses, POLL exits anyway.
- Disabled: fixed EXEC wait; DBIn is unused and RW is tied to 0.

Test Plan:
- 8-bit data 0x41 accepted at cycle 0 with default timing -> E high on cycles 9..58, DB = 0x41, RS = 1; Done pulse at about cycle 4063; Col = 1.
- BUS_4BIT = 1, command 0x28 -> two E pulses with DB[7:4] = 0x2 then 0x8, RS = 0, DB[3:0] = 0.
- COLS = 16, LINES = 2, 16 data bytes -> after the 16th, WRAP issues 0x C0 (0x80|0x40) and Line = 1, Col = 0. 32 bytes -> 0x80 is issued and Line = 0.
- Command 0x01 -> EXEC lasts 164000 cycles, Line = 0, Col = 0. InValid held during this time gets no accept until Done.
- Reset asserted during PULSE -> E = 0 on the next edge, all outputs at reset values, InReady = 1 on the following cycle, no Done.
- LCD_BUSY_POLL_EN with DBIn[7] model busy for 3 polls -> 4 read pulses with RW = 1, then Done. With DBIn[7] stuck at 1 -> exit after T_LONG_CYC.
